// File: rtl/bcd_digit_source.sv
// bcd_digit_source
//   Multi-digit packed-BCD up/down counter with a snapshot serializer.
//   A snap request freezes the current count. The serializer then offers it one
//   digit at a time, least-significant digit first, over a valid/ready handshake.
//   Each dig_out nibble is the plain 8421 code expected by the excess-3
//   converter stage: dig_out[3] is its MSB and dig_out[0] its LSB.
//
// Parameters
//   NDIG      number of BCD digits (2..8)
//   IW        digit index width
//
// Ports
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   en, up      count enable and direction (1 = up)
//   load        load load_val; takes priority over en
//   load_val    packed BCD load value; digit i is bits [4i+3:4i]
//   snap        start serializing the current count
//   dig_ready   downstream accepts dig_out
//   count       current packed BCD count
//   wrap        one-cycle pulse after an overflow or underflow wrap
//   bad_load    one-cycle pulse after a load that had a nibble above 9
//   dig_out     digit offered; dig_idx is its position (0 = LSD)
//   dig_valid   dig_out is valid
//   busy        serializer not idle
//   done        one-cycle pulse after the last digit is accepted
module bcd_digit_source #(
  parameter int NDIG = 4,
  parameter int IW   = $clog2(NDIG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic                snap,
  input  logic                dig_ready,
  output logic [4*NDIG-1:0]   count,
  output logic                wrap,
  output logic                bad_load,
  output logic [3:0]          dig_out,
  output logic [IW-1:0]       dig_idx,
  output logic                dig_valid,
  output logic                busy,
  output logic                done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  logic [4*NDIG-1:0] count_reg;
  logic              wrap_reg;
  logic              bad_load_reg;
  logic [4*NDIG-1:0] snap_reg;
  state_t            state_reg;
  logic [3:0]        dig_out_reg;
  logic [IW-1:0]     dig_idx_reg;
  logic              dig_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  // Load sanitising: out-of-range nibbles become 0 and are flagged.
  logic [4*NDIG-1:0] load_clean;
  logic [NDIG-1:0]   load_bad;

  // Ripple chains: up_carry[i] / dn_borrow[i] means digit i must step.
  // Digit 0 always steps, so the chains start at 1.
  logic [NDIG:0]     up_carry;
  logic [NDIG:0]     dn_borrow;
  logic [4*NDIG-1:0] inc_val;
  logic [4*NDIG-1:0] dec_val;

  // Snapshot split into addressable digits for the serializer mux.
  logic [3:0]        snap_dig [NDIG];
  logic [IW-1:0]     idx_inc;

  assign up_carry[0]  = 1'b1;
  assign dn_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] raw;
      logic       at_nine;
      logic       at_zero;

      assign cur     = count_reg[4*gi +: 4];
      assign raw     = load_val[4*gi +: 4];
      assign at_nine = (cur == 4'd9);
      assign at_zero = (cur == 4'd0);

      assign load_bad[gi]          = (raw > 4'd9);
      assign load_clean[4*gi +: 4] = load_bad[gi] ? 4'd0 : raw;

      assign inc_val[4*gi +: 4] = !up_carry[gi] ? cur :
                                  (at_nine ? 4'd0 : cur + 4'd1);
      assign dec_val[4*gi +: 4] = !dn_borrow[gi] ? cur :
                                  (at_zero ? 4'd9 : cur - 4'd1);

      assign up_carry[gi+1]  = up_carry[gi] & at_nine;
      assign dn_borrow[gi+1] = dn_borrow[gi] & at_zero;

      assign snap_dig[gi] = snap_reg[4*gi +: 4];
    end
  endgenerate

  assign idx_inc = dig_idx_reg + IW'(1);

  // Counter. A carry/borrow out of the top digit is exactly the wrap event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      wrap_reg     <= 1'b0;
      bad_load_reg <= 1'b0;
    end else if (load) begin
      count_reg    <= load_clean;
      wrap_reg     <= 1'b0;
      bad_load_reg <= |load_bad;
    end else if (en) begin
      count_reg    <= up ? inc_val : dec_val;
      wrap_reg     <= up ? up_carry[NDIG] : dn_borrow[NDIG];
      bad_load_reg <= 1'b0;
    end else begin
      wrap_reg     <= 1'b0;
      bad_load_reg <= 1'b0;
    end
  end

  // Serializer. The snapshot takes count_reg before this edge's update, so a
  // snap coinciding with a load or count step sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      snap_reg      <= '0;
      dig_out_reg   <= 4'd0;
      dig_idx_reg   <= '0;
      dig_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (snap) begin
            state_reg     <= ST_SEND;
            snap_reg      <= count_reg;
            dig_out_reg   <= count_reg[3:0];
            dig_idx_reg   <= '0;
            dig_valid_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        ST_SEND: begin
          // snap is ignored here. Outputs hold until a handshake occurs.
          if (dig_valid_reg && dig_ready) begin
            if (dig_idx_reg < LAST_IDX) begin
              dig_idx_reg <= idx_inc;
              dig_out_reg <= snap_dig[idx_inc];
            end else begin
              state_reg     <= ST_IDLE;
              dig_idx_reg   <= '0;
              dig_out_reg   <= 4'd0;
              dig_valid_reg <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
            end
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          dig_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign count     = count_reg;
  assign wrap      = wrap_reg;
  assign bad_load  = bad_load_reg;
  assign dig_out   = dig_out_reg;
  assign dig_idx   = dig_idx_reg;
  assign dig_valid = dig_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
